// File: rtl/f32_addsub_arbiter.sv
// Round-robin front end for two requesters sharing one combinational float32 add/sub datapath.
// Operands are held on DP_* for WAIT_CYCLES cycles before the result is captured and returned.
module f32_addsub_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             REQ0_VALID,
    output logic             REQ0_READY,
    input  logic [31:0]      REQ0_A,
    input  logic [31:0]      REQ0_B,
    input  logic             REQ0_OP,
    input  logic             REQ1_VALID,
    output logic             REQ1_READY,
    input  logic [31:0]      REQ1_A,
    input  logic [31:0]      REQ1_B,
    input  logic             REQ1_OP,
    output logic             RSP0_VALID,
    input  logic             RSP0_READY,
    output logic             RSP1_VALID,
    input  logic             RSP1_READY,
    output logic [31:0]      RSP_R,
    output logic             RSP_UNDERFLOW,
    output logic             RSP_OVERFLOW,
    output logic [31:0]      DP_A,
    output logic [31:0]      DP_B,
    output logic             DP_OP,
    input  logic [31:0]      DP_R,
    input  logic             DP_UNDERFLOW,
    input  logic             DP_OVERFLOW,
    output logic             BUSY,
    output logic [CNT_W-1:0] OVF_COUNT
);

    localparam int SET_W = $clog2(WAIT_CYCLES + 1);

    generate
        if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
            $error("WAIT_CYCLES must be in the range 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RESP
    } state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             grant_q, grant_d;
    logic [SET_W-1:0] cnt_q, cnt_d;
    logic [31:0]      dp_a_q, dp_a_d;
    logic [31:0]      dp_b_q, dp_b_d;
    logic             dp_op_q, dp_op_d;
    logic [31:0]      rsp_r_q, rsp_r_d;
    logic             rsp_unf_q, rsp_unf_d;
    logic             rsp_ovf_q, rsp_ovf_d;
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    logic             winner;
    logic             rsp_done;

    // On a tie the requester that was not served last wins; otherwise the lone valid one wins.
    always_comb begin
        winner = REQ1_VALID;
        if (REQ0_VALID && REQ1_VALID) begin
            winner = ~last_grant_q;
        end
    end

    assign REQ0_READY = (state_q == IDLE) && REQ0_VALID && !winner;
    assign REQ1_READY = (state_q == IDLE) && REQ1_VALID && winner;
    assign rsp_done   = (state_q == RESP) && (grant_q ? RSP1_READY : RSP0_READY);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        dp_a_d       = dp_a_q;
        dp_b_d       = dp_b_q;
        dp_op_d      = dp_op_q;
        rsp_r_d      = rsp_r_q;
        rsp_unf_d    = rsp_unf_q;
        rsp_ovf_d    = rsp_ovf_q;
        ovf_cnt_d    = ovf_cnt_q;
        case (state_q)
            IDLE: begin
                if (REQ0_READY) begin
                    dp_a_d  = REQ0_A;
                    dp_b_d  = REQ0_B;
                    dp_op_d = REQ0_OP;
                    grant_d = 1'b0;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end else if (REQ1_READY) begin
                    dp_a_d  = REQ1_A;
                    dp_b_d  = REQ1_B;
                    dp_op_d = REQ1_OP;
                    grant_d = 1'b1;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q + SET_W'(1);
                if (cnt_q == SET_W'(WAIT_CYCLES - 1)) begin
                    rsp_r_d   = DP_R;
                    rsp_unf_d = DP_UNDERFLOW;
                    rsp_ovf_d = DP_OVERFLOW;
                    if (DP_OVERFLOW && (ovf_cnt_q != {CNT_W{1'b1}})) begin
                        ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_done) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            cnt_q        <= '0;
            dp_a_q       <= '0;
            dp_b_q       <= '0;
            dp_op_q      <= 1'b0;
            rsp_r_q      <= '0;
            rsp_unf_q    <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            ovf_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            dp_a_q       <= dp_a_d;
            dp_b_q       <= dp_b_d;
            dp_op_q      <= dp_op_d;
            rsp_r_q      <= rsp_r_d;
            rsp_unf_q    <= rsp_unf_d;
            rsp_ovf_q    <= rsp_ovf_d;
            ovf_cnt_q    <= ovf_cnt_d;
        end
    end

    assign RSP0_VALID    = (state_q == RESP) && !grant_q;
    assign RSP1_VALID    = (state_q == RESP) && grant_q;
    assign RSP_R         = rsp_r_q;
    assign RSP_UNDERFLOW = rsp_unf_q;
    assign RSP_OVERFLOW  = rsp_ovf_q;
    assign DP_A          = dp_a_q;
    assign DP_B          = dp_b_q;
    assign DP_OP         = dp_op_q;
    assign BUSY          = (state_q != IDLE);
    assign OVF_COUNT     = ovf_cnt_q;

endmodule
